freelist: RTL

FREELIST -- requirements
Module: freelist

---
 rtl/freelist_pkg.sv | 23 ++
 rtl/freelist_if.sv | 25 ++
 rtl/freelist_compact.sv | 42 ++++
 rtl/freelist.sv | 98 +++++++++
 4 files changed

// File: rtl/freelist_pkg.sv
// Shared types for the physical-register free list.
//   freelist_cfg_t : (NPR, NARCH) configuration constant set
//   com_bundle_t   : per-slot commit bundle (opid, rollback flag, prda pair)
package freelist_pkg;

    localparam int PRD_W = 16;   // {valid, index}
    localparam int IDX_W = 15;

    typedef struct packed {
        logic [15:0] npr;    // total physical registers
        logic [15:0] narch;  // registers mapped at reset
    } freelist_cfg_t;

    localparam freelist_cfg_t FL_CFG = '{npr: 16'd128, narch: 16'd65};

    // prda[0] is the current mapping, prda[1] the previous one.
    typedef struct packed {
        logic [15:0]      opid;      // bit 15 marks a live slot
        logic             rollback;
        logic [1:0][15:0] prda;
    } com_bundle_t;

endpackage

// File: rtl/freelist_if.sv
// Rename/commit bus of the free list.
//   ren_req/ren_gnt/ren_prd : allocation request, grant, allocated register
//   com                     : commit bundles (release source)
//   free_cnt/err_ovf        : occupancy and sticky overflow flag
interface freelist_if #(
    parameter int NREN = 2,
    parameter int NCOM = 2
) ();
    logic [NREN-1:0]                         ren_req;
    logic [NREN-1:0]                         ren_gnt;
    logic [NREN-1:0][15:0]                   ren_prd;
    freelist_pkg::com_bundle_t [NCOM-1:0]    com;
    logic [15:0]                             free_cnt;
    logic                                    err_ovf;

    modport master (
        output ren_req, com,
        input  ren_gnt, ren_prd, free_cnt, err_ovf
    );

    modport slave (
        input  ren_req, com,
        output ren_gnt, ren_prd, free_cnt, err_ovf
    );
endinterface

// File: rtl/freelist_compact.sv
// Release selection and compaction.
//   i_com   : commit bundles
//   o_idx   : released indices packed towards slot 0, in slot order
//   o_cnt   : number of valid entries in o_idx
module freelist_compact
    import freelist_pkg::*;
#(
    parameter int NCOM = 2,
    localparam int RW  = $clog2(NCOM + 1)
) (
    input  com_bundle_t [NCOM-1:0]        i_com,
    output logic [NCOM-1:0][IDX_W-1:0]    o_idx,
    output logic [RW-1:0]                 o_cnt
);

    logic [NCOM-1:0]             w_vld;
    logic [NCOM-1:0][15:0]       w_sel;

    // Rollback frees the current mapping, normal commit frees the previous one.
    // Index 0 and invalid values are never returned to the list.
    always_comb begin
        for (int k = 0; k < NCOM; k++) begin
            w_sel[k] = i_com[k].rollback ? i_com[k].prda[0] : i_com[k].prda[1];
            w_vld[k] = i_com[k].opid[15] & w_sel[k][15] & (|w_sel[k][IDX_W-1:0]);
        end
    end

    // Running prefix sum gives each valid slot its output position.
    always_comb begin : compact
        logic [RW-1:0] run;
        run   = '0;
        o_idx = '0;
        for (int k = 0; k < NCOM; k++) begin
            for (int j = 0; j < NCOM; j++)
                if (w_vld[k] && run == RW'(j))
                    o_idx[j] = w_sel[k][IDX_W-1:0];
            run = run + RW'(w_vld[k]);
        end
        o_cnt = run;
    end

endmodule

// File: rtl/freelist.sv
// Physical-register free list: circular FIFO of free indices.
//   clk, rst_n : clock, async active-low reset
//   bus        : rename allocation / commit release / status (freelist_if.slave)
module freelist
    import freelist_pkg::*;
#(
    parameter int NPR   = int'(FL_CFG.npr),
    parameter int NARCH = int'(FL_CFG.narch),
    parameter int NREN  = 2,
    parameter int NCOM  = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    freelist_if.slave bus
);

    localparam int DEPTH = NPR - NARCH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int RW    = $clog2(NCOM + 1);

    logic [IDX_W-1:0] r_fifo [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;

    logic [NREN-1:0]             w_gnt;
    logic [NREN-1:0][15:0]       w_prd;
    logic [NCOM-1:0][IDX_W-1:0]  w_rel_idx;
    logic [RW-1:0]               w_rel_cnt;
    int                          w_gcnt;
    int                          w_room;
    int                          w_acc;
    logic                        w_ovf_hit;

    // Pointer advance modulo a depth that need not be a power of two.
    function automatic logic [AW-1:0] wrap(input logic [AW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= DEPTH) s = s - DEPTH;
        return AW'(s);
    endfunction

    freelist_compact #(.NCOM(NCOM)) u_compact (
        .i_com (bus.com),
        .o_idx (w_rel_idx),
        .o_cnt (w_rel_cnt)
    );

    // Grants form a contiguous run from slot 0 limited by the registered count;
    // this cycle's releases are not visible here (no bypass).
    always_comb begin : grant
        logic          run;
        logic [AW-1:0] ptr;
        run    = 1'b1;
        w_gcnt = 0;
        w_prd  = '0;
        ptr    = '0;
        for (int i = 0; i < NREN; i++) begin
            w_gnt[i] = run & rst_n & bus.ren_req[i] & (int'(r_cnt) > i);
            run      = w_gnt[i];
            ptr      = wrap(r_head, i);
            if (w_gnt[i]) w_prd[i] = {1'b1, r_fifo[ptr]};
            w_gcnt   = w_gcnt + int'(w_gnt[i]);
        end
    end

    // Slots vacated by this cycle's grants count as room for releases.
    always_comb begin
        w_room    = DEPTH - int'(r_cnt) + w_gcnt;
        w_ovf_hit = int'(w_rel_cnt) > w_room;
        w_acc     = w_ovf_hit ? w_room : int'(w_rel_cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) r_fifo[k] <= IDX_W'(NARCH + k);
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= CW'(DEPTH);
            r_ovf  <= 1'b0;
        end else begin
            for (int j = 0; j < NCOM; j++)
                if (j < w_acc) r_fifo[wrap(r_tail, j)] <= w_rel_idx[j];
            r_head <= wrap(r_head, w_gcnt);
            r_tail <= wrap(r_tail, w_acc);
            r_cnt  <= CW'(int'(r_cnt) - w_gcnt + w_acc);
            if (w_ovf_hit) r_ovf <= 1'b1;
        end
    end

    assign bus.ren_gnt  = w_gnt;
    assign bus.ren_prd  = w_prd;
    assign bus.free_cnt = 16'(r_cnt);
    assign bus.err_ovf  = r_ovf;

endmodule
